// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU beside EX: one quotient bit per clock,
// result presented as {remainder, quotient} and held until EX drops start_i.
//
// state  | meaning
// FREE   | idle, result and ready cleared, waiting for an accepted start
// BYZERO | divisor was zero; result forced to 0 on the next edge
// ON     | iterating one restoring step per clock, then sign fix-up
// END    | result held with ready high until start_i drops
module div #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W:0]   work;
    logic [DATA_W-1:0]   div_abs;
    logic                sgn_q;
    logic                neg1_q;
    logic                neg2_q;

    logic [DATA_W-1:0]   op1_abs;
    logic [DATA_W-1:0]   op2_abs;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    always_comb begin
        op1_abs = opdata1_i;
        op2_abs = opdata2_i;
        if (signed_div_i && opdata1_i[DATA_W-1]) begin
            op1_abs = -opdata1_i;
        end
        if (signed_div_i && opdata2_i[DATA_W-1]) begin
            op2_abs = -opdata2_i;
        end
    end

    // The work register carries a built-in left shift, so the partial
    // remainder under test is always the slice just above the quotient bits.
    always_comb begin
        diff = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, div_abs};
        quo  = work[DATA_W-1:0];
        rem  = work[2*DATA_W:DATA_W+1];
        quo_fix = quo;
        rem_fix = rem;
        if (sgn_q && (neg1_q ^ neg2_q)) begin
            quo_fix = -quo;
        end
        if (sgn_q && neg1_q) begin
            rem_fix = -rem;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            work     <= '0;
            div_abs  <= '0;
            sgn_q    <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        sgn_q  <= signed_div_i;
                        neg1_q <= opdata1_i[DATA_W-1];
                        neg2_q <= opdata2_i[DATA_W-1];
                        if (opdata2_i == '0) begin
                            state <= BYZERO;
                        end else begin
                            state   <= ON;
                            cnt     <= '0;
                            div_abs <= op2_abs;
                            work    <= {{DATA_W{1'b0}}, op1_abs, 1'b0};
                        end
                    end
                end
                BYZERO: begin
                    state    <= END;
                    result_o <= '0;
                    ready_o  <= 1'b1;
                end
                ON: begin
                    if (annul_i) begin
                        state   <= FREE;
                        cnt     <= '0;
                        ready_o <= 1'b0;
                    end else if (cnt != CNT_LAST) begin
                        if (diff[DATA_W]) begin
                            work <= {work[2*DATA_W-1:0], 1'b0};
                        end else begin
                            work <= {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
                        end
                        cnt <= cnt + 1'b1;
                    end else begin
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= 1'b1;
                        cnt      <= '0;
                        state    <= END;
                    end
                end
                END: begin
                    if (!start_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: begin
                    state <= FREE;
                end
            endcase
        end
    end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle radix-2 restoring divider sequencer that serves the execute stage for DIV/DIVU.
- EX raises start_i and holds its stall request while this block iterates. On ready_o, EX writes result_o into HI/LO: HI = remainder, LO = quotient.
- Sits beside EX and is clocked with the pipeline. Only EX drives it.

Parameters:
- DATA_W, 32, operand width. The result is 2*DATA_W. The iteration count equals DATA_W.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, synchronous, active-high
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  DATA_W  dividend
- opdata2_i  in  DATA_W  divisor
- start_i  in  1  request; EX holds it high until it has consumed ready_o
- annul_i  in  1  cancel the in-flight or pending divide (flush/exception)
- result_o  out  2*DATA_W  {remainder, quotient}
- ready_o  out  1  result valid

Behaviour:
- Reset values:
  - state = FREE, cnt = 0, work register = 0.
  - result_o = 0, ready_o = 0.
  - rst mid-operation aborts at once; no result is produced.
- States and transitions:
  - FREE:
    - If start_i && !annul_i and opdata2_i == 0 -> BYZERO.
    - If start_i && !annul_i and opdata2_i != 0 -> ON, with:
      - cnt = 0.
      - Load the absolute values of both operands when signed_div_i = 1 and the operand MSB = 1 (two's-complement negate); otherwise load them raw.
      - Work register (2*DATA_W+1 bits) = {DATA_W zeros, |dividend|, 1'b0}.
    - Operands and signed_div_i are captured into internal registers at this edge. Later input changes are ignored.
    - Otherwise stay in FREE. ready_o = 0, result_o = 0.
  - BYZERO:
    - Next edge -> END with result_o = 0 and ready_o = 1.
  - ON:
    - If annul_i -> FREE. cnt = 0, ready_o = 0.
    - Else if cnt != DATA_W, perform one restoring step per clock:
      - diff = {1'b0, rem_part} - {1'b0, |divisor|}.
      - If diff[DATA_W] = 1 (negative): shift the work register left by 1, LSB = 0.
      - Else: work register = {diff[DATA_W-1:0], quotient_part, 1'b1}.
      - cnt++.
    - Else (cnt == DATA_W):
      - If signed, negate the quotient when the captured sign bits differ.
      - If signed, negate the remainder when the captured dividend was negative.
      - Load result_o = {remainder, quotient}, ready_o = 1, cnt = 0, state -> END.
  - END:
    - Hold result_o and ready_o while start_i = 1. annul_i is ignored in END.
    - When start_i = 0 -> FREE. ready_o = 0 and result_o = 0 at that edge.
- Latency:
  - Start accepted at edge E0. DATA_W steps at E1..E32. Fix-up at E33.
  - ready_o is first high after E33, i.e. 33 cycles after acceptance for DATA_W = 32.
  - Divide-by-zero: ready_o is high after E1.
- Boundary cases:
  - start_i while in ON, BYZERO or END does not restart the divide.
  - start_i and annul_i high in FREE: the start is not accepted.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000 (wraps), remainder 0. No trap.
  - Signed remainder takes the sign of the dividend. Quotient truncates toward zero.
  - The unsigned path never negates, even when the MSB = 1.
  - Annul in ON on the same edge the fix-up would occur: the annul wins, and ready_o never rises.

Test Plan:
- Unsigned 100 / 7, start held -> ready_o rises 33 cycles after acceptance. result_o = {0x00000002, 0x0000000E}. Drop start_i -> ready_o = 0 next cycle.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Signed 7 / -2 -> {0x00000001, 0xFFFFFFFD}.
- Unsigned 0xFFFFFFFF / 0x10 -> {0x0000000F, 0x0FFFFFFF}. Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
- Divisor 0 (either mode) -> BYZERO then END. ready_o high 1 cycle after acceptance, result_o = 0.
- annul_i pulsed at step 10 -> FREE next edge, ready_o stays 0. New start 5 / 5 is accepted next cycle -> {0, 1} after 33 cycles.
- rst asserted mid-ON -> result_o = 0 and ready_o = 0 next edge. Operand inputs toggled during ON do not change a 1000 / 3 result of {1, 333}.
